// File: rtl/uart_pkg.sv
// Shared UART definitions: shifter states, frame width
// and the divisor helper used by both transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int DATA_BITS = 8;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags
// the last cycle of each bit; held at zero while clr is high.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic bit_end
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_end = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_unit.sv
// UART 8N1 transmitter: one-entry holding register feeding
// an LSB-first shifter; back-to-back frames with no idle gap.
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int BAUD     = 115200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_t            r_state;
  tx_state_t            w_state_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 r_hold_full;
  logic [DATA_BITS-1:0] r_hold_data;
  logic [DATA_BITS-1:0] r_shift;
  logic [BW-1:0]        r_bit_cnt;
  logic [BW-1:0]        w_bit_cnt_nxt;
  logic                 w_load;
  logic                 w_shift_en;
  logic                 w_done;
  logic                 w_accept;
  logic                 w_bit_end;
  logic                 w_cnt_clr;

  assign w_accept  = tx_start && !r_hold_full;
  assign w_cnt_clr = (r_state == IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_cnt_clr),
    .bit_end(w_bit_end)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_tx_nxt      = r_tx;
    w_bit_cnt_nxt = r_bit_cnt;
    w_load        = 1'b0;
    w_shift_en    = 1'b0;
    w_done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_load      = 1'b1;
          w_tx_nxt    = 1'b0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_tx_nxt      = r_shift[0];
          w_bit_cnt_nxt = '0;
          w_state_nxt   = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = STOP;
          end else begin
            w_shift_en    = 1'b1;
            w_tx_nxt      = r_shift[1];
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_done = 1'b1;
          // chain straight into the next start bit when a byte waits
          if (r_hold_full) begin
            w_load      = 1'b1;
            w_tx_nxt    = 1'b0;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_tx        <= 1'b1;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx      <= w_tx_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      if (w_load) begin
        r_shift <= r_hold_data;
      end else if (w_shift_en) begin
        r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
      end
      if (w_accept) begin
        r_hold_full <= 1'b1;
        r_hold_data <= tx_data;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  assign tx           = r_tx;
  assign tx_ready     = !r_hold_full;
  assign tx_busy      = (r_state != IDLE);
  assign tx_done_tick = w_done;

endmodule
